// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the control FSM: instruction opcodes (taken from the
// upper byte of an instruction word), FSM state encodings and a small decode
// helper.
// ----------------------------------------------------------------------------
package cpu_pkg;

    // Opcodes
    localparam logic [7:0] OP_INPUT     = 8'h01;
    localparam logic [7:0] OP_MOV       = 8'h02;
    localparam logic [7:0] OP_LOAD      = 8'h03;
    localparam logic [7:0] OP_STORE     = 8'h04;
    localparam logic [7:0] OP_PUSH      = 8'h05;
    localparam logic [7:0] OP_PULL      = 8'h06;
    localparam logic [7:0] OP_ALU_FIRST = 8'h10;
    localparam logic [7:0] OP_ALU_LAST  = 8'h15;
    localparam logic [7:0] OP_JMP       = 8'h20;
    localparam logic [7:0] OP_HALT      = 8'hFF;

    // FSM states
    localparam int unsigned STATE_W = 4;
    localparam logic [STATE_W-1:0] S_FETCH = 4'd0;
    localparam logic [STATE_W-1:0] S_IMM   = 4'd1;
    localparam logic [STATE_W-1:0] S_LD_A  = 4'd2;
    localparam logic [STATE_W-1:0] S_LD_D  = 4'd3;
    localparam logic [STATE_W-1:0] S_ST_A  = 4'd4;
    localparam logic [STATE_W-1:0] S_ST_D  = 4'd5;
    localparam logic [STATE_W-1:0] S_PUSH  = 4'd6;
    localparam logic [STATE_W-1:0] S_PULL  = 4'd7;
    localparam logic [STATE_W-1:0] S_JMP   = 4'd8;
    localparam logic [STATE_W-1:0] S_HALT  = 4'd9;

    function automatic logic is_alu_op(input logic [7:0] op);
        return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
    endfunction

endpackage

// File: rtl/stack_ptr.sv
// ----------------------------------------------------------------------------
// stack_ptr
// Full-descending stack pointer with bound checks. The pointer addresses the
// most recently pushed word; STACK_TOP itself is never written, so an empty
// stack has sp == STACK_TOP.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : decrement sp (ignored when full)
//   i_pull     : increment sp (ignored when empty)
//   o_sp       : current stack pointer
//   o_full     : STACK_DEPTH words are stacked
//   o_empty    : nothing is stacked
// ----------------------------------------------------------------------------
module stack_ptr #(
    parameter int unsigned          ADDR_W      = 16,
    parameter logic [ADDR_W-1:0]    STACK_TOP   = 16'hFFFF,
    parameter int unsigned          STACK_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pull,
    output logic [ADDR_W-1:0] o_sp,
    output logic              o_full,
    output logic              o_empty
);

    logic [ADDR_W-1:0] r_sp;
    logic              w_full;
    logic              w_empty;

    // Occupancy is measured as distance below the top, modulo 2^ADDR_W.
    assign w_full  = ((STACK_TOP - r_sp) == ADDR_W'(STACK_DEPTH));
    assign w_empty = (r_sp == STACK_TOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= STACK_TOP;
        end else if (i_push && !w_full) begin
            r_sp <= r_sp - ADDR_W'(1);
        end else if (i_pull && !w_empty) begin
            r_sp <= r_sp + ADDR_W'(1);
        end
    end

    assign o_sp    = r_sp;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/control_fsm.sv
// ----------------------------------------------------------------------------
// control_fsm
// Instruction sequencer for a small accumulator-less core. Fetches 16-bit
// words from a combinational memory, drives register-file transfers and
// memory writes. Every output is a register, so each state's memory address
// is set up on the edge that enters it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   mem_addr/en/we/wdata: memory request, mem_rdata returns mem[mem_addr]
//   reg_rdata           : register-file read data at reg_from
//   mov_en/reg_from/to  : one-cycle register transfer strobe and addresses
//   operand             : immediate, loaded word or ALU op code
//   pc, halted, stack_err: architectural status
// ----------------------------------------------------------------------------
module control_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       RA_W        = 4,
    parameter logic [ADDR_W-1:0] STACK_TOP   = 16'hFFFF,
    parameter int unsigned       STACK_DEPTH = 256,
    parameter logic [RA_W-1:0]   IMM_SRC     = 4'hA,
    parameter logic [RA_W-1:0]   ALU_SRC     = 4'hD
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              mov_en,
    output logic [RA_W-1:0]   reg_from,
    output logic [RA_W-1:0]   reg_to,
    output logic [DATA_W-1:0] operand,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              stack_err
);

    logic [STATE_W-1:0] r_state,    w_state_nxt;
    logic               r_push_wr,  w_push_wr_nxt;
    logic [ADDR_W-1:0]  r_pc,       w_pc_nxt;
    logic [ADDR_W-1:0]  r_ea,       w_ea_nxt;
    logic [DATA_W-1:0]  r_operand,  w_operand_nxt;
    logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_nxt;
    logic               r_mem_en,   w_mem_en_nxt;
    logic               r_mem_we,   w_mem_we_nxt;
    logic [DATA_W-1:0]  r_mem_wdata, w_mem_wdata_nxt;
    logic               r_mov_en,   w_mov_en_nxt;
    logic [RA_W-1:0]    r_reg_from, w_reg_from_nxt;
    logic [RA_W-1:0]    r_reg_to,   w_reg_to_nxt;
    logic               r_halted,   w_halted_nxt;
    logic               r_stack_err, w_stack_err_nxt;

    logic [7:0]         w_opcode;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic [ADDR_W-1:0]  w_rdata_addr;
    logic               w_sp_push;
    logic               w_sp_pull;
    logic [ADDR_W-1:0]  w_sp;
    logic               w_sp_full;
    logic               w_sp_empty;

    assign w_opcode     = mem_rdata[15:8];
    assign w_pc_inc     = r_pc + ADDR_W'(1);
    assign w_rdata_addr = ADDR_W'(mem_rdata);

    stack_ptr #(
        .ADDR_W      (ADDR_W),
        .STACK_TOP   (STACK_TOP),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_sp_push),
        .i_pull  (w_sp_pull),
        .o_sp    (w_sp),
        .o_full  (w_sp_full),
        .o_empty (w_sp_empty)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_push_wr_nxt   = 1'b0;
        w_pc_nxt        = r_pc;
        w_ea_nxt        = r_ea;
        w_operand_nxt   = r_operand;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_en_nxt    = r_mem_en;
        w_mem_we_nxt    = 1'b0;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mov_en_nxt    = 1'b0;
        w_reg_from_nxt  = r_reg_from;
        w_reg_to_nxt    = r_reg_to;
        w_halted_nxt    = r_halted;
        w_stack_err_nxt = r_stack_err;
        w_sp_push       = 1'b0;
        w_sp_pull       = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_pc_nxt       = w_pc_inc;
                w_mem_addr_nxt = w_pc_inc;
                if (is_alu_op(w_opcode)) begin
                    w_reg_from_nxt = ALU_SRC;
                    w_reg_to_nxt   = RA_W'(mem_rdata[3:0]);
                    w_operand_nxt  = DATA_W'(mem_rdata[11:8]);
                    w_mov_en_nxt   = 1'b1;
                end else begin
                    case (w_opcode)
                        OP_INPUT: begin
                            w_reg_from_nxt = IMM_SRC;
                            w_reg_to_nxt   = RA_W'(mem_rdata[3:0]);
                            w_state_nxt    = S_IMM;
                        end
                        OP_MOV: begin
                            w_reg_from_nxt = RA_W'(mem_rdata[7:4]);
                            w_reg_to_nxt   = RA_W'(mem_rdata[3:0]);
                            w_mov_en_nxt   = 1'b1;
                        end
                        OP_LOAD: begin
                            // Destination is captured now; the opcode word is gone by LD_D.
                            w_reg_from_nxt = IMM_SRC;
                            w_reg_to_nxt   = RA_W'(mem_rdata[3:0]);
                            w_state_nxt    = S_LD_A;
                        end
                        OP_STORE: begin
                            w_reg_from_nxt = RA_W'(mem_rdata[7:4]);
                            w_state_nxt    = S_ST_A;
                        end
                        OP_PUSH: begin
                            w_reg_from_nxt = RA_W'(mem_rdata[7:4]);
                            w_state_nxt    = S_PUSH;
                        end
                        OP_PULL: begin
                            w_reg_from_nxt = IMM_SRC;
                            w_reg_to_nxt   = RA_W'(mem_rdata[3:0]);
                            w_mem_addr_nxt = w_sp;
                            w_state_nxt    = S_PULL;
                        end
                        OP_JMP: begin
                            w_state_nxt = S_JMP;
                        end
                        OP_HALT: begin
                            w_pc_nxt       = r_pc;
                            w_mem_addr_nxt = r_mem_addr;
                            w_mem_en_nxt   = 1'b0;
                            w_halted_nxt   = 1'b1;
                            w_state_nxt    = S_HALT;
                        end
                        default: ; // unknown opcode: NOP
                    endcase
                end
            end
            S_IMM: begin
                w_operand_nxt  = mem_rdata;
                w_mov_en_nxt   = 1'b1;
                w_pc_nxt       = w_pc_inc;
                w_mem_addr_nxt = w_pc_inc;
                w_state_nxt    = S_FETCH;
            end
            S_LD_A: begin
                w_ea_nxt       = w_rdata_addr;
                w_pc_nxt       = w_pc_inc;
                w_mem_addr_nxt = w_rdata_addr;
                w_state_nxt    = S_LD_D;
            end
            S_LD_D: begin
                w_operand_nxt  = mem_rdata;
                w_mov_en_nxt   = 1'b1;
                w_mem_addr_nxt = r_pc;
                w_state_nxt    = S_FETCH;
            end
            S_ST_A: begin
                // reg_from has been stable since FETCH, so reg_rdata is valid here.
                w_ea_nxt        = w_rdata_addr;
                w_pc_nxt        = w_pc_inc;
                w_mem_addr_nxt  = w_rdata_addr;
                w_mem_wdata_nxt = reg_rdata;
                w_mem_we_nxt    = 1'b1;
                w_state_nxt     = S_ST_D;
            end
            S_ST_D: begin
                w_mem_addr_nxt = r_pc;
                w_state_nxt    = S_FETCH;
            end
            S_PUSH: begin
                // Two phases: capture reg_rdata and address, then the write cycle.
                if (r_push_wr) begin
                    w_mem_addr_nxt = r_pc;
                    w_state_nxt    = S_FETCH;
                end else if (w_sp_full) begin
                    w_stack_err_nxt = 1'b1;
                    w_mem_addr_nxt  = r_pc;
                    w_state_nxt     = S_FETCH;
                end else begin
                    w_sp_push       = 1'b1;
                    w_mem_addr_nxt  = w_sp - ADDR_W'(1);
                    w_mem_wdata_nxt = reg_rdata;
                    w_mem_we_nxt    = 1'b1;
                    w_push_wr_nxt   = 1'b1;
                end
            end
            S_PULL: begin
                if (w_sp_empty) begin
                    w_stack_err_nxt = 1'b1;
                end else begin
                    w_operand_nxt = mem_rdata;
                    w_mov_en_nxt  = 1'b1;
                    w_sp_pull     = 1'b1;
                end
                w_mem_addr_nxt = r_pc;
                w_state_nxt    = S_FETCH;
            end
            S_JMP: begin
                w_pc_nxt       = w_rdata_addr;
                w_mem_addr_nxt = w_rdata_addr;
                w_state_nxt    = S_FETCH;
            end
            S_HALT: ; // parked until reset
            default: begin
                w_mem_addr_nxt = r_pc;
                w_state_nxt    = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_push_wr   <= 1'b0;
            r_pc        <= '0;
            r_ea        <= '0;
            r_operand   <= '0;
            r_mem_addr  <= '0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_mov_en    <= 1'b0;
            r_reg_from  <= '0;
            r_reg_to    <= '0;
            r_halted    <= 1'b0;
            r_stack_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_push_wr   <= w_push_wr_nxt;
            r_pc        <= w_pc_nxt;
            r_ea        <= w_ea_nxt;
            r_operand   <= w_operand_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mov_en    <= w_mov_en_nxt;
            r_reg_from  <= w_reg_from_nxt;
            r_reg_to    <= w_reg_to_nxt;
            r_halted    <= w_halted_nxt;
            r_stack_err <= w_stack_err_nxt;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign mov_en    = r_mov_en;
    assign reg_from  = r_reg_from;
    assign reg_to    = r_reg_to;
    assign operand   = r_operand;
    assign pc        = r_pc;
    assign halted    = r_halted;
    assign stack_err = r_stack_err;

endmodule

// File: tb/tb_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_control_fsm
// Directed bench for control_fsm: combinational 64K-word memory model and a
// 16-entry register-file read model; expected values are hand-derived.
// ----------------------------------------------------------------------------
module tb_control_fsm;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] reg_rdata;
    logic        mov_en;
    logic [3:0]  reg_from;
    logic [3:0]  reg_to;
    logic [15:0] operand;
    logic [15:0] pc;
    logic        halted;
    logic        stack_err;

    logic [15:0] mem  [0:65535];
    logic [15:0] regs [0:15];

    int          n_checks;
    int          n_errors;
    int          wr_count;
    logic [15:0] last_waddr;
    logic        overlap_seen;

    control_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .reg_rdata (reg_rdata),
        .mov_en    (mov_en),
        .reg_from  (reg_from),
        .reg_to    (reg_to),
        .operand   (operand),
        .pc        (pc),
        .halted    (halted),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign reg_rdata = regs[reg_from];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_count      = wr_count + 1;
            last_waddr    = mem_addr;
        end
    end

    always @(negedge clk) begin
        if (mov_en && mem_we) overlap_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic clear_env();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
        wr_count   = 0;
        last_waddr = 16'h0000;
    endtask

    task automatic start_reset();
        rst_n = 1'b0;
        clear_env();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        overlap_seen = 1'b0;
        clear_env();

        // Reset values while reset is held
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_en", mem_en, 1'b1);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);
        chk("rst_mov_en", mov_en, 1'b0);
        chk("rst_reg_from", reg_from, 4'h0);
        chk("rst_reg_to", reg_to, 4'h0);
        chk("rst_operand", operand, 16'h0000);
        chk("rst_halted", halted, 1'b0);
        chk("rst_stack_err", stack_err, 1'b0);

        // Input immediate: 0x0103, 0x1234
        mem[0] = 16'h0103;
        mem[1] = 16'h1234;
        release_reset();
        tick(1);
        chk("in_c1_reg_from", reg_from, 4'hA);
        chk("in_c1_reg_to", reg_to, 4'h3);
        chk("in_c1_mov_en", mov_en, 1'b0);
        chk("in_c1_pc", pc, 16'h0001);
        tick(1);
        chk("in_c2_mov_en", mov_en, 1'b1);
        chk("in_c2_operand", operand, 16'h1234);
        chk("in_c2_pc", pc, 16'h0002);
        chk("in_c2_reg_to", reg_to, 4'h3);
        tick(1);
        chk("in_c3_mov_en", mov_en, 1'b0);
        chk("in_c3_pc", pc, 16'h0003);

        // Store: 0x0405, 0x0040, reg0 = 0xBEEF
        start_reset();
        mem[0]  = 16'h0405;
        mem[1]  = 16'h0040;
        regs[0] = 16'hBEEF;
        regs[5] = 16'h5555;
        release_reset();
        tick(1);
        chk("st_c1_mem_we", mem_we, 1'b0);
        chk("st_c1_pc", pc, 16'h0001);
        tick(1);
        chk("st_c2_mem_we", mem_we, 1'b1);
        chk("st_c2_mem_addr", mem_addr, 16'h0040);
        chk("st_c2_mem_wdata", mem_wdata, 16'hBEEF);
        chk("st_c2_mov_en", mov_en, 1'b0);
        tick(1);
        chk("st_c3_mem_we", mem_we, 1'b0);
        chk("st_c3_pc", pc, 16'h0002);
        chk("st_c3_mem_addr", mem_addr, 16'h0002);
        chk("st_wr_count", wr_count, 1);
        chk("st_mem_0040", mem[16'h0040], 16'hBEEF);

        // Push r1 then pull to r1, then pull on an empty stack
        start_reset();
        mem[0]  = 16'h0510;
        mem[1]  = 16'h0601;
        mem[2]  = 16'h0602;
        regs[1] = 16'hCAFE;
        release_reset();
        tick(1);
        chk("push_c1_mem_we", mem_we, 1'b0);
        chk("push_c1_reg_from", reg_from, 4'h1);
        tick(1);
        chk("push_c2_mem_we", mem_we, 1'b1);
        chk("push_c2_mem_addr", mem_addr, 16'hFFFE);
        chk("push_c2_mem_wdata", mem_wdata, 16'hCAFE);
        tick(1);
        chk("push_c3_mem_we", mem_we, 1'b0);
        chk("push_c3_pc", pc, 16'h0001);
        chk("push_mem_fffe", mem[16'hFFFE], 16'hCAFE);
        tick(1);
        chk("pull_c4_mem_addr", mem_addr, 16'hFFFE);
        chk("pull_c4_mov_en", mov_en, 1'b0);
        tick(1);
        chk("pull_c5_mov_en", mov_en, 1'b1);
        chk("pull_c5_operand", operand, 16'hCAFE);
        chk("pull_c5_reg_to", reg_to, 4'h1);
        chk("pull_c5_reg_from", reg_from, 4'hA);
        chk("pull_c5_stack_err", stack_err, 1'b0);
        tick(2);
        chk("pull2_c7_stack_err", stack_err, 1'b1);
        chk("pull2_c7_mov_en", mov_en, 1'b0);
        chk("pull2_c7_pc", pc, 16'h0003);

        // Pull at reset sp
        start_reset();
        mem[0] = 16'h0602;
        release_reset();
        tick(1);
        chk("pe_c1_mem_addr", mem_addr, 16'hFFFF);
        tick(1);
        chk("pe_c2_stack_err", stack_err, 1'b1);
        chk("pe_c2_mov_en", mov_en, 1'b0);
        chk("pe_c2_pc", pc, 16'h0001);
        tick(1);
        chk("pe_c3_stack_err", stack_err, 1'b1);
        chk("pe_c3_pc", pc, 16'h0002);

        // Jump then halt
        start_reset();
        mem[0]        = 16'h2000;
        mem[1]        = 16'h0010;
        mem[16'h0010] = 16'hFF00;
        release_reset();
        tick(2);
        chk("jmp_c2_pc", pc, 16'h0010);
        chk("jmp_c2_halted", halted, 1'b0);
        tick(1);
        chk("halt_c3_halted", halted, 1'b1);
        chk("halt_c3_mem_en", mem_en, 1'b0);
        chk("halt_c3_pc", pc, 16'h0010);
        tick(5);
        chk("halt_c8_pc", pc, 16'h0010);
        chk("halt_c8_halted", halted, 1'b1);
        chk("halt_c8_strobes", {mov_en, mem_we}, 2'b00);

        // Reset during the store write cycle
        start_reset();
        mem[0]  = 16'h0405;
        mem[1]  = 16'h0040;
        regs[0] = 16'hBEEF;
        release_reset();
        tick(2);
        chk("rst_std_mem_we_pre", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_std_mem_we", mem_we, 1'b0);
        chk("rst_std_pc", pc, 16'h0000);
        chk("rst_std_mem_addr", mem_addr, 16'h0000);
        release_reset();
        chk("rst_std_wr_count", wr_count, 0);
        chk("rst_std_pc_after", pc, 16'h0000);

        // ALU, mov, load, unknown opcode
        start_reset();
        mem[0]        = 16'h1357;
        mem[1]        = 16'h0254;
        mem[2]        = 16'h0309;
        mem[3]        = 16'h0100;
        mem[4]        = 16'h7700;
        mem[16'h0100] = 16'h5A5A;
        release_reset();
        tick(1);
        chk("alu_mov_en", mov_en, 1'b1);
        chk("alu_reg_from", reg_from, 4'hD);
        chk("alu_reg_to", reg_to, 4'h7);
        chk("alu_operand", operand, 16'h0003);
        tick(1);
        chk("mov_mov_en", mov_en, 1'b1);
        chk("mov_reg_from", reg_from, 4'h5);
        chk("mov_reg_to", reg_to, 4'h4);
        chk("mov_pc", pc, 16'h0002);
        tick(2);
        chk("ld_c4_mem_addr", mem_addr, 16'h0100);
        chk("ld_c4_mov_en", mov_en, 1'b0);
        tick(1);
        chk("ld_c5_mov_en", mov_en, 1'b1);
        chk("ld_c5_operand", operand, 16'h5A5A);
        chk("ld_c5_reg_from", reg_from, 4'hA);
        chk("ld_c5_reg_to", reg_to, 4'h9);
        chk("ld_c5_pc", pc, 16'h0004);
        tick(1);
        chk("nop_pc", pc, 16'h0005);
        chk("nop_strobes", {mov_en, mem_we}, 2'b00);

        // Stack overflow after STACK_DEPTH pushes
        start_reset();
        for (int i = 0; i < 257; i++) mem[i] = 16'h0500;
        regs[0] = 16'h1111;
        release_reset();
        tick(768);
        chk("ovf_c768_stack_err", stack_err, 1'b0);
        chk("ovf_c768_wr_count", wr_count, 256);
        chk("ovf_c768_last_waddr", last_waddr, 16'hFEFF);
        chk("ovf_c768_pc", pc, 16'h0100);
        tick(2);
        chk("ovf_c770_stack_err", stack_err, 1'b1);
        chk("ovf_c770_wr_count", wr_count, 256);
        chk("ovf_c770_pc", pc, 16'h0101);
        chk("ovf_c770_mem_we", mem_we, 1'b0);

        // pc wraps modulo 2^16
        start_reset();
        mem[0] = 16'h2000;
        mem[1] = 16'hFFFF;
        release_reset();
        tick(2);
        chk("wrap_c2_pc", pc, 16'hFFFF);
        tick(1);
        chk("wrap_c3_pc", pc, 16'h0000);
        chk("wrap_c3_mem_addr", mem_addr, 16'h0000);

        chk("no_mov_we_overlap", overlap_seen, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
